// File: rtl/iaf_ctrl_pkg.sv
// Shared definitions for the integrate-and-fire frame sequencer:
// state encoding and width helpers.
package iaf_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_FIRE  = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned win_width(input int unsigned neurons);
        return (clog2(neurons) < 1) ? 1 : clog2(neurons);
    endfunction

    function automatic int unsigned lat_width(input int unsigned read_cycles);
        return clog2(read_cycles);
    endfunction

endpackage

// File: rtl/spike_sync.sv
// Per-neuron spike conditioning: 2-flop synchronizer, edge history and a
// one-cycle rising-edge pulse gated by the read window.
module spike_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_spike,
    input  logic i_load,
    input  logic i_en,
    output logic o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    // On load, history takes the value r_sync is about to hold, so a level
    // already present at window entry never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_meta <= i_spike;
            r_sync <= r_meta;
            r_hist <= i_load ? r_meta : r_sync;
        end
    end

    assign o_edge = i_en & r_sync & ~r_hist;

endmodule

// File: rtl/iaf_frame_ctrl.sv
// Frame sequencer for an integrate-and-fire neuron array: clear, load, trigger,
// read the first spike as the winner, and report winner and latency.
module iaf_frame_ctrl
    import iaf_ctrl_pkg::*;
#(
    parameter  int unsigned INPUTS      = 25,
    parameter  int unsigned NEURONS     = 4,
    parameter  int unsigned CLR_CYCLES  = 2,
    parameter  int unsigned SETTLE      = 2,
    parameter  int unsigned READ_CYCLES = 64,
    localparam int unsigned WIN_W       = win_width(NEURONS),
    localparam int unsigned LAT_W       = lat_width(READ_CYCLES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INPUTS-1:0]  in_pixels,
    output logic [INPUTS-1:0]  sig_out,
    output logic               trig_out,
    output logic               re_out,
    output logic               rstb_out,
    input  logic [NEURONS-1:0] spike_in,
    output logic               latinhib_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIN_W-1:0]   out_winner,
    output logic               out_fired,
    output logic [LAT_W-1:0]   out_latency
);

    localparam int unsigned CNT_MAX_A = (CLR_CYCLES > SETTLE) ? CLR_CYCLES : SETTLE;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > READ_CYCLES) ? CNT_MAX_A : READ_CYCLES;
    localparam int unsigned CNT_W     = clog2(CNT_MAX + 1);

    logic [2:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [INPUTS-1:0]  r_frame;
    logic               r_rstb;
    logic [WIN_W-1:0]   r_winner;
    logic               r_fired;
    logic [LAT_W-1:0]   r_latency;

    logic [NEURONS-1:0] w_edge;
    logic [WIN_W-1:0]   w_win;
    logic               w_hit;
    logic               w_load;
    logic               w_read;

    assign w_load = (r_state == ST_FIRE);
    assign w_read = (r_state == ST_READ);

    for (genvar g = 0; g < NEURONS; g++) begin : g_sync
        spike_sync u_sync (
            .clk     (clk),
            .rst     (rst),
            .i_spike (spike_in[g]),
            .i_load  (w_load),
            .i_en    (w_read),
            .o_edge  (w_edge[g])
        );
    end

    always_comb begin
        w_win = '0;
        w_hit = 1'b0;
        for (int unsigned i = 0; i < NEURONS; i++) begin
            if (w_edge[i] && !w_hit) begin
                w_win = WIN_W'(i);
                w_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_frame   <= '0;
            r_rstb    <= 1'b0;
            r_winner  <= '0;
            r_fired   <= 1'b0;
            r_latency <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_frame <= in_pixels;
                        r_rstb  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == CNT_W'(CLR_CYCLES - 1)) begin
                        r_rstb  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (r_cnt == CNT_W'(SETTLE - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_FIRE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FIRE: begin
                    r_cnt   <= '0;
                    r_state <= ST_READ;
                end
                ST_READ: begin
                    if (w_hit) begin
                        r_winner  <= w_win;
                        r_fired   <= 1'b1;
                        r_latency <= r_cnt[LAT_W-1:0];
                        r_state   <= ST_DONE;
                    end else if (r_cnt == CNT_W'(READ_CYCLES - 1)) begin
                        r_winner  <= '0;
                        r_fired   <= 1'b0;
                        r_latency <= LAT_W'(READ_CYCLES - 1);
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = (r_state == ST_IDLE);
    assign rstb_out     = r_rstb;
    assign sig_out      = (r_state == ST_LOAD || r_state == ST_FIRE || w_read) ? r_frame : '0;
    assign trig_out     = (r_state == ST_FIRE);
    assign re_out       = w_read;
    // Inhibition starts combinationally in the capture cycle, then holds through DONE.
    assign latinhib_out = (w_read && w_hit) || (r_state == ST_DONE && r_fired);
    assign out_valid    = (r_state == ST_DONE);
    assign out_winner   = r_winner;
    assign out_fired    = r_fired;
    assign out_latency  = r_latency;

endmodule

// File: tb/tb_iaf_frame_ctrl.sv
// Self-checking bench for iaf_frame_ctrl: per-frame timing checks plus a
// scoreboard of expected results popped at each output handshake.
module tb_iaf_frame_ctrl;

    localparam int unsigned INPUTS      = 25;
    localparam int unsigned NEURONS     = 4;
    localparam int unsigned CLR_CYCLES  = 2;
    localparam int unsigned SETTLE      = 2;
    localparam int unsigned READ_CYCLES = 64;
    localparam int          TRIG_CYC    = CLR_CYCLES + SETTLE + 1;

    typedef struct packed {
        logic [1:0] win;
        logic       fired;
        logic [5:0] lat;
    } res_t;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [INPUTS-1:0]   in_pixels;
    logic [INPUTS-1:0]   sig_out;
    logic                trig_out;
    logic                re_out;
    logic                rstb_out;
    logic [NEURONS-1:0]  spike_in;
    logic                latinhib_out;
    logic                out_valid;
    logic                out_ready;
    logic [1:0]          out_winner;
    logic                out_fired;
    logic [5:0]          out_latency;

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t sb[$];

    iaf_frame_ctrl #(
        .INPUTS      (INPUTS),
        .NEURONS     (NEURONS),
        .CLR_CYCLES  (CLR_CYCLES),
        .SETTLE      (SETTLE),
        .READ_CYCLES (READ_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pixels    (in_pixels),
        .sig_out      (sig_out),
        .trig_out     (trig_out),
        .re_out       (re_out),
        .rstb_out     (rstb_out),
        .spike_in     (spike_in),
        .latinhib_out (latinhib_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_winner   (out_winner),
        .out_fired    (out_fired),
        .out_latency  (out_latency)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"},    32'(in_ready),     32'd1);
        chk({tag, "_rstb"},        32'(rstb_out),     32'd0);
        chk({tag, "_sig"},         32'(sig_out),      32'd0);
        chk({tag, "_trig"},        32'(trig_out),     32'd0);
        chk({tag, "_re"},          32'(re_out),       32'd0);
        chk({tag, "_latinhib"},    32'(latinhib_out), 32'd0);
        chk({tag, "_out_valid"},   32'(out_valid),    32'd0);
        chk({tag, "_out_winner"},  32'(out_winner),   32'd0);
        chk({tag, "_out_fired"},   32'(out_fired),    32'd0);
        chk({tag, "_out_latency"}, 32'(out_latency),  32'd0);
    endtask

    // Called at a negedge with the DUT idle. spk_at is the READ cycle index in
    // which spk is raised (-1 for none); bp is the number of DONE cycles with
    // out_ready low; stale is a spike level held from before the accept.
    task automatic do_frame(input logic [24:0] px, input logic [3:0] spk, input int spk_at,
                            input int bp, input logic [3:0] stale,
                            input logic [1:0] e_win, input logic e_fired, input logic [5:0] e_lat);
        res_t r;
        int   n_read;
        int   guard;
        sb.push_back(res_t'{win: e_win, fired: e_fired, lat: e_lat});
        spike_in  = stale;
        out_ready = (bp == 0);
        in_pixels = px;
        in_valid  = 1'b1;
        chk("idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_pixels = '0;
        for (int c = 1; c <= TRIG_CYC; c++) begin
            chk("rstb",  32'(rstb_out), 32'(c > CLR_CYCLES));
            chk("sig",   32'(sig_out),  (c > CLR_CYCLES) ? 32'(px) : 32'd0);
            chk("trig",  32'(trig_out), 32'(c == TRIG_CYC));
            chk("busy",  32'(in_ready), 32'd0);
            chk("re_pre", 32'(re_out),  32'd0);
            @(negedge clk);
        end
        chk("re_start", 32'(re_out), 32'd1);
        n_read = 0;
        guard  = 0;
        while (!out_valid && guard < 200) begin
            if (re_out) begin
                chk("sig_read",  32'(sig_out),  32'(px));
                chk("trig_read", 32'(trig_out), 32'd0);
                if (n_read == spk_at) spike_in = spike_in | spk;
                n_read++;
            end
            guard++;
            @(negedge clk);
        end
        chk("done_reached", 32'(out_valid), 32'd1);
        chk("read_cycles",  32'(n_read),    32'(e_lat) + 32'd1);
        chk("latinhib",     32'(latinhib_out), 32'(e_fired));
        chk("sig_done",     32'(sig_out),   32'd0);
        chk("re_done",      32'(re_out),    32'd0);
        chk("rstb_done",    32'(rstb_out),  32'd1);
        for (int i = 0; i < bp; i++) begin
            in_valid  = 1'b1;
            in_pixels = ~px;
            spike_in  = spike_in ^ 4'hF;
            chk("bp_valid",   32'(out_valid),   32'd1);
            chk("bp_ready",   32'(in_ready),    32'd0);
            chk("bp_winner",  32'(out_winner),  32'(e_win));
            chk("bp_fired",   32'(out_fired),   32'(e_fired));
            chk("bp_latency", 32'(out_latency), 32'(e_lat));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            r = sb.pop_front();
            chk("sb_valid",   32'(out_valid),   32'd1);
            chk("sb_winner",  32'(out_winner),  32'(r.win));
            chk("sb_fired",   32'(out_fired),   32'(r.fired));
            chk("sb_latency", 32'(out_latency), 32'(r.lat));
        end
        @(negedge clk);
        chk("valid_drop",    32'(out_valid),    32'd0);
        chk("ready_back",    32'(in_ready),     32'd1);
        chk("latinhib_idle", 32'(latinhib_out), 32'd0);
        chk("rstb_idle",     32'(rstb_out),     32'd1);
        spike_in = '0;
        @(negedge clk);
    endtask

    initial begin
        int guard;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pixels = '0;
        spike_in  = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("rst_hold");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("rst_idle");

        do_frame(25'h1ABCDEF, 4'b0100, 10, 0, 4'b0000, 2'd2, 1'b1, 6'd12);
        do_frame(25'h0000001, 4'b1010,  3, 0, 4'b0000, 2'd1, 1'b1, 6'd5);
        do_frame(25'h1555555, 4'b0000, -1, 0, 4'b0000, 2'd0, 1'b0, 6'd63);
        do_frame(25'h0AAAAAA, 4'b1000,  5, 5, 4'b0001, 2'd3, 1'b1, 6'd7);
        do_frame(25'h1234567, 4'b0010, 61, 0, 4'b0000, 2'd1, 1'b1, 6'd63);
        do_frame(25'h0765432, 4'b0010, 62, 0, 4'b0000, 2'd0, 1'b0, 6'd63);
        do_frame(25'h0F00F00, 4'b0001,  0, 0, 4'b0000, 2'd0, 1'b1, 6'd2);

        // Abort a frame in the middle of its read window.
        in_pixels = 25'h0F0F0F0;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!re_out && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        chk("re_before_rst", 32'(re_out), 32'd1);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1 chk_reset("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("rst_after");

        do_frame(25'h1FFFFFF, 4'b0100, 4, 0, 4'b0000, 2'd2, 1'b1, 6'd6);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
